// File: rtl/pixel_capture.sv
// Pixel capture engine: grabs one video frame on request and streams
// {address, colour} words through a small FIFO to a framebuffer write port.
module pixel_capture #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        frame,
    input  logic        de,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [18:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        short_err,
    output logic        line_err,
    output logic [18:0] pix_count
);

    localparam logic [18:0] TotalPix = 19'(H_ACTIVE * V_ACTIVE);
    localparam logic [18:0] LineLen  = 19'(H_ACTIVE);
    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] Depth  = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StArmed, StCapture, StDrain, StDone} state_e;

    state_e            state_q;
    logic [30:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW:0]     count_q;
    logic [18:0]       index_q;
    logic [18:0]       run_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              push_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == Depth);
    assign pop        = wr_valid && wr_ready;
    // The frame cycle itself never carries a captured pixel.
    assign push       = (state_q == StCapture) && de && !frame;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok    = push && (!fifo_full || pop);

    // Write port always shows the FIFO head; forced to zero while empty.
    always_comb begin
        wr_valid = !fifo_empty;
        wr_addr  = '0;
        wr_data  = '0;
        if (!fifo_empty) begin
            wr_addr = mem_q[rd_ptr_q][30:12];
            wr_data = mem_q[rd_ptr_q][11:0];
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {index_q, r, g, b};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Capture FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            short_err <= 1'b0;
            line_err  <= 1'b0;
            pix_count <= '0;
            index_q   <= '0;
            run_q     <= '0;
        end else begin
            // Dropped pixel: the index still advances so addresses stay aligned.
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_q   <= StArmed;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        short_err <= 1'b0;
                        line_err  <= 1'b0;
                        pix_count <= '0;
                    end
                end
                StArmed: begin
                    if (frame) begin
                        state_q <= StCapture;
                        index_q <= '0;
                        run_q   <= '0;
                    end
                end
                StCapture: begin
                    if (frame) begin
                        // Early frame start: abandon the rest, run is not checked.
                        short_err <= 1'b1;
                        state_q   <= StDrain;
                    end else if (de) begin
                        index_q <= index_q + 19'd1;
                        run_q   <= run_q + 19'd1;
                        if (pix_count != TotalPix) begin
                            pix_count <= pix_count + 19'd1;
                        end
                        if (index_q == TotalPix - 19'd1) begin
                            state_q <= StDrain;
                        end
                    end else begin
                        // Non-zero run means de just fell.
                        if (run_q != '0 && run_q != LineLen) begin
                            line_err <= 1'b1;
                        end
                        run_q <= '0;
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_capture.sv
// Self-checking bench for pixel_capture: directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.
module tb_pixel_capture;

    localparam int unsigned H     = 4;
    localparam int unsigned V     = 2;
    localparam int unsigned D     = 4;
    localparam int unsigned TOTAL = H * V;

    localparam int PIdle    = 0;
    localparam int PArmed   = 1;
    localparam int PCapture = 2;
    localparam int PDrain   = 3;
    localparam int PDone    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        frame;
    logic        de;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        short_err;
    logic        line_err;
    logic [18:0] pix_count;

    pixel_capture #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .frame     (frame),
        .de        (de),
        .r         (r),
        .g         (g),
        .b         (b),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .short_err (short_err),
        .line_err  (line_err),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int          m_phase = PIdle;
    logic [30:0] m_q[$];
    int          m_idx   = 0;
    int          m_pix   = 0;
    int          m_run   = 0;
    bit          m_ovf   = 0;
    bit          m_short = 0;
    bit          m_line  = 0;
    logic [18:0] wlog[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_busy;
        exp_busy = (m_phase == PArmed) || (m_phase == PCapture) || (m_phase == PDrain);
        check_eq("wr_valid", 32'(wr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("wr_addr", 32'(wr_addr), 32'(m_q[0][30:12]));
            check_eq("wr_data", 32'(wr_data), 32'(m_q[0][11:0]));
        end
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("done", 32'(done), 32'(m_phase == PDone));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("short_err", 32'(short_err), 32'(m_short));
        check_eq("line_err", 32'(line_err), 32'(m_line));
        check_eq("pix_count", 32'(pix_count), 32'(m_pix));
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_update();
        bit          pop_m;
        bit          acc;
        logic [30:0] word;
        pop_m = (m_q.size() != 0) && wr_ready;
        acc   = 0;
        word  = '0;
        if (rst) begin
            m_q.delete();
            m_phase = PIdle;
            m_ovf   = 0;
            m_short = 0;
            m_line  = 0;
            m_pix   = 0;
            m_idx   = 0;
            m_run   = 0;
            return;
        end
        case (m_phase)
            PIdle, PDone: begin
                if (arm) begin
                    m_phase = PArmed;
                    m_ovf   = 0;
                    m_short = 0;
                    m_line  = 0;
                    m_pix   = 0;
                end
            end
            PArmed: begin
                if (frame) begin
                    m_phase = PCapture;
                    m_idx   = 0;
                    m_run   = 0;
                end
            end
            PCapture: begin
                if (frame) begin
                    m_short = 1;
                    m_phase = PDrain;
                end else if (de) begin
                    word = {19'(m_idx), r, g, b};
                    acc  = (m_q.size() < D) || pop_m;
                    if (!acc) m_ovf = 1;
                    if (m_idx == TOTAL - 1) m_phase = PDrain;
                    m_idx++;
                    m_run++;
                    if (m_pix < TOTAL) m_pix++;
                end else begin
                    if (m_run != 0 && m_run != H) m_line = 1;
                    m_run = 0;
                end
            end
            PDrain: begin
                if (m_q.size() == 0) m_phase = PDone;
            end
            default: m_phase = PIdle;
        endcase
        if (pop_m) void'(m_q.pop_front());
        if (acc) m_q.push_back(word);
    endtask

    // One clock: drive inputs, compare outputs, update model, advance.
    task automatic step(input bit a, input bit f, input bit d, input bit rdy, input bit rs);
        arm      = a;
        frame    = f;
        de       = d;
        wr_ready = rdy;
        rst      = rs;
        r        = 4'($urandom);
        g        = 4'($urandom);
        b        = 4'($urandom);
        check_outputs();
        if (wr_valid && wr_ready && !rst) wlog.push_back(wr_addr);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 1, rdy, 0);
    endtask

    task automatic gap(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
    endtask

    task automatic start_frame(input bit rdy);
        wlog.delete();
        step(1, 0, 0, rdy, 0);
        step(0, 0, 1, rdy, 0);
        step(0, 1, 1, rdy, 0);
    endtask

    task automatic wait_done(input string tag, input bit rdy);
        int n;
        n = 0;
        while (!done && n < 100) begin
            step(0, 0, 0, rdy, 0);
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string tag, input int n);
        check_eq({tag, "_count"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            check_eq(tag, 32'(wlog[i]), 32'(i));
        end
    endtask

    initial begin
        rst      = 1'b1;
        arm      = 1'b0;
        frame    = 1'b0;
        de       = 1'b0;
        wr_ready = 1'b1;
        r        = '0;
        g        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pix_count", 32'(pix_count), 32'd0);

        // Full frame, sink always ready.
        start_frame(1);
        pixels(4, 1);
        gap(2, 1);
        pixels(4, 1);
        wait_done("s1_done", 1);
        check_log("s1_addr", 8);
        check_eq("s1_pix_count", 32'(pix_count), 32'd8);
        check_eq("s1_flags", 32'({overflow, short_err, line_err}), 32'd0);

        // Sink stalled: first four held, rest dropped.
        start_frame(0);
        pixels(4, 0);
        gap(2, 0);
        pixels(4, 0);
        gap(3, 0);
        check_eq("s2_overflow", 32'(overflow), 32'd1);
        check_eq("s2_held_addr", 32'(wr_addr), 32'd0);
        wait_done("s2_done", 1);
        check_log("s2_addr", 4);

        // Frame pulse after five pixels.
        start_frame(1);
        pixels(4, 1);
        gap(1, 1);
        pixels(1, 1);
        step(0, 1, 1, 1, 0);
        wait_done("s3_done", 1);
        check_eq("s3_short_err", 32'(short_err), 32'd1);
        check_eq("s3_pix_count", 32'(pix_count), 32'd5);
        check_log("s3_addr", 5);

        // Short line: flagged, capture carries on at address 3.
        start_frame(1);
        pixels(3, 1);
        gap(1, 1);
        check_eq("s4_line_err", 32'(line_err), 32'd1);
        check_eq("s4_busy", 32'(busy), 32'd1);
        pixels(5, 1);
        wait_done("s4_done", 1);
        check_log("s4_addr", 8);

        // Reset mid-capture with two words queued.
        start_frame(0);
        pixels(2, 0);
        check_eq("s5_pre_valid", 32'(wr_valid), 32'd1);
        step(0, 0, 1, 0, 1);
        check_eq("s5_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("s5_busy", 32'(busy), 32'd0);
        check_eq("s5_flags", 32'({done, overflow, short_err, line_err}), 32'd0);
        check_eq("s5_pix_count", 32'(pix_count), 32'd0);
        start_frame(1);
        pixels(4, 1);
        gap(1, 1);
        pixels(4, 1);
        wait_done("s5_done", 1);
        check_log("s5_addr", 8);

        // Arm during capture is ignored.
        start_frame(1);
        pixels(2, 1);
        step(1, 0, 1, 1, 0);
        pixels(1, 1);
        gap(1, 1);
        pixels(4, 1);
        wait_done("s6_done", 1);
        check_log("s6_addr", 8);
        check_eq("s6_pix_count", 32'(pix_count), 32'd8);
        check_eq("s6_short_err", 32'(short_err), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_capture.md
PIXEL_CAPTURE -- requirements
Module: pixel_capture

Interface
REQ-001 SHALL provide parameters: H_ACTIVE, default 640, active pixels per line; V_ACTIVE, default 480, active lines per frame; FIFO_DEPTH, default 4, pixel FIFO entries (power of two, at least 2).
REQ-002 SHALL provide ports: clk  in  1  single clock, all logic rising-edge.
REQ-003 SHALL provide ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL provide ports: arm  in  1  one-cycle request to capture the next frame.
REQ-005 SHALL provide ports: frame  in  1  one-cycle pulse marking start of a video frame.
REQ-006 SHALL provide ports: de  in  1  data enable; pixel present when high.
REQ-007 SHALL provide ports: r, g, b  in  4 each  pixel colour.
REQ-008 SHALL provide ports: wr_valid  out  1; wr_ready  in  1; wr_addr  out  19; wr_data  out  12 ({r,g,b}) as the framebuffer write port.
REQ-009 SHALL provide ports: busy  out  1; done  out  1; overflow  out  1; short_err  out  1; line_err  out  1; pix_count  out  19.

Function
REQ-010 SHALL implement states IDLE, ARMED, CAPTURE, DRAIN, DONE; busy is high in ARMED, CAPTURE and DRAIN.
REQ-011 SHALL, on arm in IDLE or DONE: go to ARMED, and clear done, overflow, short_err, line_err and pix_count. arm in any other state is ignored.
REQ-012 SHALL, in ARMED: ignore de until frame=1, then enter CAPTURE on the next cycle with pixel index 0. A pixel with de=1 on the frame cycle itself is not captured.
REQ-013 SHALL, in CAPTURE on each de=1 cycle: push {addr=index, data={r,g,b}} into the FIFO, then increment the index and pix_count.
REQ-014 SHALL enter DRAIN on the cycle after the push with index H_ACTIVE*V_ACTIVE-1.
REQ-015 SHALL handle frame=1 in CAPTURE before the full count as follows: set short_err, enter DRAIN, and do not capture that cycle's pixel.
REQ-016 SHALL, when a push arrives while the FIFO is full and no pop occurs that cycle: drop the pixel, set overflow (sticky), and still increment the index so later addresses stay aligned.
REQ-017 SHALL allow a simultaneous push and pop while full; occupancy is unchanged and overflow is not set.
REQ-018 SHALL drive wr_valid=1 exactly when the FIFO is non-empty, and present the head entry on wr_addr/wr_data.
REQ-019 SHALL transfer a word on a cycle with wr_valid&wr_ready; while wr_valid&!wr_ready, wr_addr/wr_data hold stable.
REQ-020 SHALL provide latency: a pixel pushed at cycle N into an empty FIFO appears with wr_valid=1 at cycle N+1.
REQ-021 SHALL, in DRAIN: enter DONE when the FIFO is empty. done=1 from that cycle until the next arm or reset.
REQ-022 SHALL check line lengths during CAPTURE: count consecutive de=1 cycles per run; on de falling 1->0, a run length not equal to H_ACTIVE sets line_err (sticky). A run cut short by the transition to DRAIN is not checked.
REQ-023 SHALL saturate pix_count at H_ACTIVE*V_ACTIVE; all arithmetic is unsigned 19-bit.
REQ-024 SHALL leave wr_* behaviour independent of state; words remaining in the FIFO drain in DONE and IDLE only if entered via reset-free paths.

Reset
REQ-025 SHALL, when rst=1 on a clock edge: state=IDLE, FIFO emptied, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, short_err=0, line_err=0, pix_count=0.
REQ-026 SHALL discard FIFO contents on reset mid-capture; no partial-frame completion.
REQ-027 SHALL give rst priority over arm, frame and de in the same cycle.

Verification
REQ-028 SHALL cover: H_ACTIVE=4, V_ACTIVE=2, wr_ready=1. Stimulus: arm, frame, then 2 lines of 4 de cycles. Response: addrs 0..7 in order, data matching, done=1, pix_count=8, no error flags.
REQ-029 SHALL cover: same frame with wr_ready=0 throughout, FIFO_DEPTH=4. Response: first 4 pixels held, pixels 4..7 dropped, overflow=1; after wr_ready=1, addrs 0..3 are written, then done=1.
REQ-030 SHALL cover: frame pulse after 5 pixels. Response: short_err=1, pix_count=5, addrs 0..4 written, done=1.
REQ-031 SHALL cover: a line of 3 de cycles followed by de=0. Response: line_err=1, capture continues, next address = 3.
REQ-032 SHALL cover: rst asserted mid-CAPTURE with 2 entries in the FIFO. Response: next cycle wr_valid=0, busy=0, all flags 0; a subsequent arm plus frame captures from address 0.
REQ-033 SHALL cover: arm while in CAPTURE. Response: ignored; capture completes normally.
